// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM array controller.
// State encoding, default widths and the read precharge pattern.
package sram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 64;

    // Bitlines are driven all-ones while a read is in flight.
    localparam logic [DATA_W_DEF-1:0] BL_PRECHARGE = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Single-access SRAM array controller: drives wordline/bitlines,
// waits for array completion or timeout, returns one response.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] wl,
    output logic              rw_sel,
    output logic [DATA_W-1:0] bl,
    input  logic              data_ready,
    input  logic              op_type,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    // Widen the package precharge constant to any bitline width.
    localparam int PRE_REP = (DATA_W + DATA_W_DEF - 1) / DATA_W_DEF;
    localparam logic [PRE_REP*DATA_W_DEF-1:0] PRE_WIDE = {PRE_REP{BL_PRECHARGE}};
    localparam logic [DATA_W-1:0] PRE = PRE_WIDE[DATA_W-1:0];

    sram_state_e       r_state;
    sram_state_e       w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              r_wr;
    logic              w_wr_nx;
    logic              r_req_ready;
    logic              w_req_ready_nx;
    logic [ADDR_W-1:0] r_wl;
    logic [ADDR_W-1:0] w_wl_nx;
    logic              r_rw_sel;
    logic              w_rw_sel_nx;
    logic [DATA_W-1:0] r_bl;
    logic [DATA_W-1:0] w_bl_nx;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nx;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [DATA_W-1:0] w_rsp_rdata_nx;
    logic              r_rsp_err;
    logic              w_rsp_err_nx;

    // Next-state and next-output logic; every output is a flop.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_wr_nx        = r_wr;
        w_req_ready_nx = 1'b0;
        w_wl_nx        = r_wl;
        w_rw_sel_nx    = r_rw_sel;
        w_bl_nx        = r_bl;
        w_rsp_valid_nx = r_rsp_valid;
        w_rsp_rdata_nx = r_rsp_rdata;
        w_rsp_err_nx   = r_rsp_err;
        unique case (r_state)
            ST_IDLE: begin
                w_req_ready_nx = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_state_nx     = ST_ISSUE;
                    w_req_ready_nx = 1'b0;
                    w_cnt_nx       = '0;
                    w_wr_nx        = req_write;
                    w_wl_nx        = req_addr;
                    w_rw_sel_nx    = req_write;
                    w_bl_nx        = req_write ? req_wdata : PRE;
                end
            end
            ST_ISSUE: begin
                if (data_ready) begin
                    w_state_nx     = ST_RESP;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_rdata_nx = r_wr ? '0 : rd_data;
                    w_rsp_err_nx   = (op_type != r_wr);
                    w_wl_nx        = '0;
                    w_rw_sel_nx    = 1'b0;
                    w_bl_nx        = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nx     = ST_RESP;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_rdata_nx = '0;
                    w_rsp_err_nx   = 1'b1;
                    w_wl_nx        = '0;
                    w_rw_sel_nx    = 1'b0;
                    w_bl_nx        = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nx     = ST_RECOVER;
                    w_rsp_valid_nx = 1'b0;
                    w_rsp_rdata_nx = '0;
                    w_rsp_err_nx   = 1'b0;
                end
            end
            ST_RECOVER: begin
                if (!data_ready) begin
                    w_state_nx     = ST_IDLE;
                    w_req_ready_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_req_ready <= 1'b0;
            r_wl        <= '0;
            r_rw_sel    <= 1'b0;
            r_bl        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_wr        <= w_wr_nx;
            r_req_ready <= w_req_ready_nx;
            r_wl        <= w_wl_nx;
            r_rw_sel    <= w_rw_sel_nx;
            r_bl        <= w_bl_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_rdata <= w_rsp_rdata_nx;
            r_rsp_err   <= w_rsp_err_nx;
        end
    end

    assign req_ready = r_req_ready;
    assign wl        = r_wl;
    assign rw_sel    = r_rw_sel;
    assign bl        = r_bl;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, wordline address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, bitline width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, the maximum number of ISSUE cycles before an error response.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all flops are clocked on its rising edge.
REQ-005 The block SHALL have port rst_l, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit, a core access request.
REQ-007 The block SHALL have port req_ready, output, 1 bit, meaning a request can be accepted.
REQ-008 The block SHALL have port req_write, input, 1 bit, 0 for read and 1 for write.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits, the S-box entry address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits, the write data.
REQ-011 The block SHALL have port wl, output, ADDR_W bits, the wordline address to the array.
REQ-012 The block SHALL have port rw_sel, output, 1 bit, the array operation (0 read, 1 write).
REQ-013 The block SHALL have port bl, output, DATA_W bits, bitline drive (write data, or all-ones precharge for a read).
REQ-014 The block SHALL have port data_ready, input, 1 bit, the array completion.
REQ-015 The block SHALL have port op_type, input, 1 bit, the operation type echoed by the array.
REQ-016 The block SHALL have port rd_data, input, DATA_W bits, array sense data, valid when data_ready is high.
REQ-017 The block SHALL have port rsp_valid, output, 1 bit, a response is available.
REQ-018 The block SHALL have port rsp_ready, input, 1 bit, the core accepts the response.
REQ-019 The block SHALL have port rsp_rdata, output, DATA_W bits, the captured read data (0 for writes).
REQ-020 The block SHALL have port rsp_err, output, 1 bit, flagging a timeout or op_type mismatch.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, RESP and RECOVER.
REQ-022 All outputs SHALL be registered.
REQ-023 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-024 On acceptance, the block SHALL capture addr, write and wdata, load wl=req_addr and rw_sel=req_write, load bl=req_wdata for a write or all-ones for a read, and go to ISSUE.
REQ-025 In ISSUE, wl, rw_sel and bl SHALL hold stable, and a cycle counter SHALL increment starting from 0.
REQ-026 When ISSUE samples data_ready=1, the block SHALL capture rd_data (0 if write) and set rsp_err = (op_type != captured write), then go to RESP.
REQ-027 On the transition out of ISSUE, wl, rw_sel and bl SHALL return to 0.
REQ-028 If the counter reaches TIMEOUT_CYC-1 in ISSUE without data_ready, the block SHALL go to RESP with rsp_err=1, rsp_rdata=0, and outputs idled.
REQ-029 If data_ready and the timeout coincide, data_ready SHALL win and normal completion SHALL apply.
REQ-030 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL hold until rsp_ready=1, then the block SHALL go to RECOVER.
REQ-031 In RECOVER, the block SHALL wait until data_ready is sampled 0, then go to IDLE, so the array pipeline drains before the next request.
REQ-032 RECOVER SHALL hold the array outputs idle.
REQ-033 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-034 Minimum throughput SHALL be one access per 5 cycles against a 2-cycle array.
REQ-035 Against the 2-cycle array (bl-ready flop on posedge, wordline flop on negedge, data_ready flop on posedge), rsp_valid SHALL rise 3 cycles after the accept edge.
REQ-036 req_valid deasserted or changing in any state other than IDLE SHALL have no effect.

Reset
REQ-037 While rst_l=0, the block SHALL asynchronously force state=IDLE, counter=0, wl=0, rw_sel=0, bl=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-038 req_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-039 Reset mid-operation (ISSUE, RESP or RECOVER) SHALL abort the access with no response emitted.

Structure
REQ-040 Shared package sram_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the BL_PRECHARGE all-ones constant.
REQ-041 The array model SHALL be a sub-module instance in the testbench only; sram_ctrl itself SHALL have no sub-modules.

Verification
REQ-042 Read at addr 8'h2A with the 2-cycle array -> wl=8'h2A, rw_sel=0, bl=all-ones for 2 cycles; rsp_valid at cycle 3; rsp_err=0.
REQ-043 Write addr 8'hFF, wdata 64'h0123_4567_89AB_CDEF -> bl equals wdata while in ISSUE; rsp_rdata=0, rsp_err=0.
REQ-044 data_ready tied 0 -> rsp_valid with rsp_err=1 exactly TIMEOUT_CYC cycles after issue; outputs idled.
REQ-045 op_type forced opposite to req_write -> rsp_err=1.
REQ-046 rsp_ready held 0 for 10 cycles -> rsp fields stable; req_ready=0 until RECOVER exits.
REQ-047 Back-to-back requests -> second accepted only after data_ready returns 0.
REQ-048 rst_l pulsed in ISSUE -> all outputs 0 immediately, and no rsp_valid after release.
